// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data RAM arbiter: default widths,
// port indices and the read-return tag.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester-side access port of the data RAM arbiter.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  req;
  logic                  we;
  logic                  lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/data_mem_arbiter_rr.sv
// Two-input round-robin pick with lock override; purely combinational.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_valid,
  input  logic       lock_idx,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_valid && req[lock_idx]) begin
      gnt = port_onehot(lock_idx);
    end else begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = port_onehot(~last);
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one registered data RAM port between the CPU (port 0) and an
// auxiliary master (port 1); returns read data to the port that issued it.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_arbiter_if.slave     m0,
  data_mem_arbiter_if.slave     m1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic       last;
  logic       lock_valid;
  logic       lock_idx;
  rd_tag_t    rd_pend;

  logic [1:0] pick;
  logic [1:0] gnt;
  logic       granted;
  logic       winner;
  logic       win_lock;

  rr_arbiter_2 u_rr (
    .req        ({m1.req, m0.req}),
    .last       (last),
    .lock_valid (lock_valid),
    .lock_idx   (lock_idx),
    .gnt        (pick)
  );

  assign gnt     = reset ? 2'b00 : pick;
  assign granted = |gnt;
  assign winner  = gnt[1];

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // Idle cycles still present port 0's address so the RAM sees a stable bus.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = m0.addr;
    ram_wdata = m0.wdata;
    win_lock  = 1'b0;
    if (gnt[0]) begin
      ram_we   = m0.we;
      win_lock = m0.lock;
    end else if (gnt[1]) begin
      ram_we    = m1.we;
      ram_addr  = m1.addr;
      ram_wdata = m1.wdata;
      win_lock  = m1.lock;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last       <= 1'b1;
      lock_valid <= 1'b0;
      lock_idx   <= PORT_CPU;
      rd_pend    <= '0;
    end else begin
      if (granted) begin
        last <= winner;
      end
      lock_valid <= granted && win_lock;
      lock_idx   <= winner;
      rd_pend    <= '{valid: granted && !ram_we, owner: winner};
    end
  end

  // Gated by reset so a read in flight when reset arrives is never returned.
  assign m0.rvalid = !reset && rd_pend.valid && (rd_pend.owner == PORT_CPU);
  assign m1.rvalid = !reset && rd_pend.valid && (rd_pend.owner == PORT_AUX);
  assign m0.rdata  = ram_rdata;
  assign m1.rdata  = ram_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural registered RAM
// and a read-return scoreboard.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0 ();
  data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1 ();

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0        (p0),
    .m1        (p1),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] exp_mem [0:65535];

  // Registered RAM, one-cycle read latency, write-through read data.
  always @(posedge clock) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_rdata         <= ram_wdata;
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    bit            owner;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t mon_e;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Read-return scoreboard: every rvalid must match the oldest expected read.
  always @(negedge clock) begin
    if (p0.rvalid === 1'b1 || p1.rvalid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected cyc=%0d got rvalid0=%b rvalid1=%b expected none",
                 cyc, p0.rvalid, p1.rvalid);
      end else begin
        mon_e = sb_q.pop_front();
        if ({p1.rvalid, p0.rvalid} !== (mon_e.owner ? 2'b10 : 2'b01) ||
            (mon_e.owner ? p1.rdata : p0.rdata) !== mon_e.data || mon_e.due != cyc) begin
          failures++;
          $display("FAIL rvalid_return cyc=%0d got rvalid={%b,%b} rdata=%h expected owner=%0d rdata=%h due=%0d",
                   cyc, p1.rvalid, p0.rvalid, (mon_e.owner ? p1.rdata : p0.rdata),
                   mon_e.owner, mon_e.data, mon_e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL rvalid_missing cyc=%0d got none expected owner=%0d rdata=%h",
               cyc, sb_q[0].owner, sb_q[0].data);
      void'(sb_q.pop_front());
    end
  end

  task automatic set_p0(input bit r, input bit w, input bit l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0.req = r; p0.we = w; p0.lock = l; p0.addr = a; p0.wdata = d;
  endtask

  task automatic set_p1(input bit r, input bit w, input bit l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1.req = r; p1.we = w; p1.lock = l; p1.addr = a; p1.wdata = d;
  endtask

  task automatic idle_all();
    set_p0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_p1(1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: apply the expected grant to the shadow memory and
  // queue the read data the granted port should receive next cycle.
  task automatic sb_push(input bit g0, input bit g1);
    rd_exp_t e;
    if (g0) begin
      if (p0.we) exp_mem[p0.addr] = p0.wdata;
      else begin
        e.owner = 1'b0; e.data = exp_mem[p0.addr]; e.due = cyc + 1;
        sb_q.push_back(e);
      end
    end else if (g1) begin
      if (p1.we) exp_mem[p1.addr] = p1.wdata;
      else begin
        e.owner = 1'b1; e.data = exp_mem[p1.addr]; e.due = cyc + 1;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sb_q.delete();
    set_p0(1'b1, 1'b1, 1'b0, 16'h0055, 16'hAAAA);
    set_p1(1'b1, 1'b0, 1'b0, 16'h0066, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({p0.gnt, p1.gnt, ram_we} !== 3'b000) begin
        failures++;
        $display("FAIL reset_gnt_we cyc=%0d got gnt0=%b gnt1=%b ram_we=%b expected 0 0 0",
                 cyc, p0.gnt, p1.gnt, ram_we);
      end
      checks++;
      if ({p0.rvalid, p1.rvalid} !== 2'b00 || ram_addr !== 16'h0055) begin
        failures++;
        $display("FAIL reset_rvalid_addr cyc=%0d got rvalid=%b%b ram_addr=%h expected 00 0055",
                 cyc, p0.rvalid, p1.rvalid, ram_addr);
      end
      tick();
    end
    reset = 1'b0;
    set_p0(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0000);
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_contest got gnt0=%b gnt1=%b expected 1 0", p0.gnt, p1.gnt);
    end
    sb_push(1'b1, 1'b0);
    tick();
    idle_all();
    @(negedge clock);
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    set_p1(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b01 || ram_addr !== 16'h0010) begin
      failures++;
      $display("FAIL single_read_gnt got gnt=%b%b ram_addr=%h expected 01 0010",
               p0.gnt, p1.gnt, ram_addr);
    end
    sb_push(1'b0, 1'b1);
    tick();
    idle_all();
    @(negedge clock);
    checks++;
    if (p1.rvalid !== 1'b1 || p0.rvalid !== 1'b0 || p1.rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_read_data got rvalid0=%b rvalid1=%b rdata=%h expected 0 1 beef",
               p0.rvalid, p1.rvalid, p1.rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_p0(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
      set_p1(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
      @(negedge clock);
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({p0.gnt, p1.gnt} !== exp_g) begin
        failures++;
        $display("FAIL rr_gnt step=%0d got gnt=%b%b expected %b", i, p0.gnt, p1.gnt, exp_g);
      end
      sb_push(exp_g[1], exp_g[0]);
      tick();
    end
    idle_all();
    @(negedge clock);
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_p0(i != 3, 1'b0, i < 3, 16'h0100, 16'h0000);
      set_p1(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i), 16'h0000);
      @(negedge clock);
      checks++;
      if ({p0.gnt, p1.gnt} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL lock_gnt step=%0d got gnt=%b%b expected %b",
                 i, p0.gnt, p1.gnt, ((i == 3) ? 2'b01 : 2'b10));
      end
      sb_push(i != 3, i == 3);
      tick();
    end
    idle_all();
    @(negedge clock);
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    set_p0(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt, ram_we} !== 3'b101 || ram_addr !== 16'h0020 || ram_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL write_drive got gnt=%b%b we=%b addr=%h wdata=%h expected 10 1 0020 1234",
               p0.gnt, p1.gnt, ram_we, ram_addr, ram_wdata);
    end
    sb_push(1'b1, 1'b0);
    tick();
    set_p0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_p1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt, ram_we} !== 3'b010 || {p0.rvalid, p1.rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL write_then_read got gnt=%b%b we=%b rvalid=%b%b expected 01 0 00",
               p0.gnt, p1.gnt, ram_we, p0.rvalid, p1.rvalid);
    end
    sb_push(1'b0, 1'b1);
    tick();
    idle_all();
    @(negedge clock);
    checks++;
    if (p1.rvalid !== 1'b1 || p1.rdata !== 16'h1234) begin
      failures++;
      $display("FAIL write_read_data got rvalid1=%b rdata=%h expected 1 1234", p1.rvalid, p1.rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_p1(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b01) begin
      failures++;
      $display("FAIL mid_reset_gnt got gnt=%b%b expected 01", p0.gnt, p1.gnt);
    end
    tick();
    reset = 1'b1;
    sb_q.delete();
    set_p0(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    set_p1(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({p0.rvalid, p1.rvalid, p0.gnt, p1.gnt} !== 4'b0000) begin
        failures++;
        $display("FAIL mid_reset_quiet step=%0d got rvalid=%b%b gnt=%b%b expected 00 00",
                 i, p0.rvalid, p1.rvalid, p0.gnt, p1.gnt);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset_contest got gnt=%b%b expected 10", p0.gnt, p1.gnt);
    end
    sb_push(1'b1, 1'b0);
    tick();
    idle_all();
    @(negedge clock);
    tick();
  endtask

  task automatic test_back_to_back();
    bit tb_last;
    bit pend0, pend1, g0, g1;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    do_reset();
    tb_last = 1'b1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!pend0)
        set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0,
               16'h0030 + 16'($urandom_range(0, 7)), 16'($urandom));
      if (!pend1)
        set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0,
               16'h0030 + 16'($urandom_range(0, 7)), 16'($urandom));
      @(negedge clock);
      if (p0.req && p1.req) begin
        g0 = tb_last;
        g1 = !tb_last;
      end else begin
        g0 = p0.req;
        g1 = p1.req;
      end
      exp_addr = g1 ? p1.addr : p0.addr;
      exp_we   = g0 ? p0.we : (g1 ? p1.we : 1'b0);
      checks++;
      if ({p0.gnt, p1.gnt} !== {g0, g1} || ram_we !== exp_we || ram_addr !== exp_addr) begin
        failures++;
        $display("FAIL b2b_mux step=%0d got gnt=%b%b we=%b addr=%h expected %b%b %b %h",
                 i, p0.gnt, p1.gnt, ram_we, ram_addr, g0, g1, exp_we, exp_addr);
      end
      sb_push(g0, g1);
      if (g0) tb_last = 1'b0;
      else if (g1) tb_last = 1'b1;
      pend0 = p0.req && !g0;
      pend1 = p1.req && !g1;
      tick();
    end
    idle_all();
    @(negedge clock);
    tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram_mem[a] = 16'(a) ^ 16'h5A5A;
      exp_mem[a] = 16'(a) ^ 16'h5A5A;
    end
    ram_mem[16'h0010] = 16'hBEEF;
    exp_mem[16'h0010] = 16'hBEEF;

    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_write_read();
    test_reset_mid();
    test_back_to_back();

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drained got pending=%0d expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single synchronous data RAM port between the CPU data interface (port 0) and a secondary bus master (port 1, e.g. a DMA or display fetch engine). It sits between the masters and the RAM's registered read/write port, which has one-cycle read latency and write-through read data. It issues round-robin grants with optional burst locking and routes the returned read data to the requester that issued the read.

## Interface
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 16, RAM data width

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mN_req  in  1  port N (N=0,1) requests an access this cycle
- mN_we  in  1  port N access is a write
- mN_lock  in  1  port N keeps ownership next cycle while req stays high
- mN_addr  in  ADDR_WIDTH  port N address
- mN_wdata  in  DATA_WIDTH  port N write data
- mN_gnt  out  1  port N access accepted this cycle (combinational)
- mN_rvalid  out  1  port N read data valid (registered)
- mN_rdata  out  DATA_WIDTH  port N read data
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM registered read data

## Operation
- State: last-winner pointer `last` (1 bit), lock owner `lock_own` (valid + index), read-return register `rd_pend` (valid + owner index).
- Grant decision each cycle, in priority order:
  - lock_own valid and that port's req high: grant that port.
  - Exactly one req high: grant it.
  - Both high: grant port != last.
  - No req: no grant.
- Mux: ram_addr/ram_wdata/ram_we from the granted port. With no grant: ram_we=0, ram_addr=m0_addr.
- On a grant edge: last <= winner. lock_own <= winner if winner's lock=1, else cleared. A lock whose req drops is cleared and ignored.
- rd_pend <= {granted && !we, winner}. A write never produces rvalid.
- mN_rvalid = rd_pend.valid && rd_pend.owner==N. Both mN_rdata = ram_rdata, qualified only by rvalid.
- Reset (any cycle, including mid-transfer): gnt/ram_we forced 0 while reset high. rd_pend cleared. lock_own cleared. last <= 1, so port 0 wins the first contested cycle.

## Timing
- Reset values: m0_gnt=m1_gnt=0, ram_we=0, m0_rvalid=m1_rvalid=0, ram_addr=m0_addr.
- Cycle N: req sampled, gnt and RAM drive valid combinationally. RAM captures at the end of N.
- Cycle N+1: owner's rvalid=1 and rdata=ram_rdata. Read latency is 1 cycle.
- Full throughput: one grant every cycle, back-to-back, with any mix of ports. Reads and writes may interleave.
- Write at N followed by a read of the same address at N+1 returns the new data; RAM ordering guarantees this.
- Requester holds req/we/addr/wdata stable until it sees gnt. Dropping req without a grant is legal.
- A locked port never waits more than 0 cycles. The unlocked port waits until the lock or req drops, so there is no starvation bound while a lock is held.

## Structure
- Shared package mem_arb_pkg: ADDR_WIDTH/DATA_WIDTH defaults, port index constants PORT_CPU=0, PORT_AUX=1, and a packed struct for the rd_pend valid+owner tag.
- Sub-module rr_arbiter_2: pure two-input round-robin pick (req[1:0], last, lock) -> onehot grant. The top level holds all registers and muxes.

## Test plan
- Reset high 2 cycles with both req high -> gnt=0, ram_we=0, rvalid=0. First cycle after release -> m0_gnt=1.
- ram[0x0010]=0xBEEF; m1 reads 0x0010 alone -> m1_gnt at N, m1_rvalid=1 at N+1 with m1_rdata=0xBEEF, m0_rvalid=0.
- Both ports request reads continuously for 4 cycles, no lock -> grants 0,1,0,1; rvalid follows one cycle later with matching owners.
- m0 req+lock for 3 cycles while m1 req held -> m0 granted cycles 1–3, m1 granted cycle 4.
- m0 writes 0x1234 to 0x0020 at N, m1 reads 0x0020 at N+1 -> no rvalid at N+1, m1_rdata=0x1234 with m1_rvalid at N+2.
- m1 read granted at N, reset high at N+1 -> m1_rvalid stays 0. After release, port 0 wins the contested grant.
